bcast_fanout_slice: RTL and testbench
=====================================

// Module: bcast_fanout_slice
// PURPOSE
//  Registered fanout stage that drives one valid/ready stream into NUM_LOADS independent consumers.
//  Sits between a single producer and a wide load group, in place of an unregistered buffer tree,
//  so the high-fanout net is retimed behind a flop boundary.
//  Each item is presented to every load and retires only after all loads have accepted it.
//  A 2-entry skid store lets the producer keep streaming at full rate when all loads accept every cycle.
// PARAMETERS
//  WIDTH      32  payload width in bits (>=1)
//  NUM_LOADS  4   number of consumer ports (2..16)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          producer has an item
//  in_ready   out  1          stage can accept; driven from a flop
//  in_data    in   WIDTH      producer payload
//  out_valid  out  NUM_LOADS  per-load valid for the head item
//  out_ready  in   NUM_LOADS  per-load ready
//  out_data   out  WIDTH      head payload, shared by all loads
// BEHAVIOUR
//  - Reset (rst=1 at edge): count=0, done_mask=0, in_ready=0, out_valid=0; out_data resets to 0.
//    in_ready rises on the first edge after rst deasserts. A mid-operation reset discards both entries and does not complete partially accepted items.
//  - Occupancy states: EMPTY(0), ONE(1), FULL(2). in_ready_q next = (count_next != FULL).
//  - Push: in_valid & in_ready. The item appears on out_data/out_valid at the next edge, a 1-cycle latency when empty.
//  - out_valid[i] = (count!=0) & ~done_mask[i]. Load i accept: out_valid[i] & out_ready[i].
//  - Retire: (done_mask | accept) == all-ones. On retire, done_mask clears to 0 and the second entry becomes head.
//    Otherwise done_mask |= accept.
//  - Simultaneous push+retire: count is unchanged, and the new item is written to the freed slot in the same cycle.
//    From EMPTY, the pushed item becomes head.
//  - FULL: in_ready=0 and in_valid is ignored. The producer must hold in_data/in_valid until accepted.
//  - A load may hold out_ready high before valid. A load that has accepted sees out_valid[i]=0 until the next item.
//  - Data stability: out_data is constant while count!=0 and no retire occurs.
//  - Order is preserved. No item is dropped or duplicated, and each load sees every item exactly once.
//  - Transitions: EMPTY-push->ONE; ONE-push&~ret->FULL; ONE-ret&~push->EMPTY;
//    FULL-ret->ONE; all other combinations hold.
// CONFIGURATION
//  BCAST_FANOUT_STATS_EN defined:
//    adds outputs stat_items[31:0] (retired item count) and stat_stall[31:0] (cycles with count!=0 and no retire).
//    Both are flops, reset to 0, increment by 1, and wrap 0xFFFF_FFFF->0.
//  Undefined: the ports and counters are absent; the datapath is identical in both builds.
// STRUCTURE
//  Package bcast_pkg: typedef enum {EMPTY, ONE, FULL} occ_e; localparam MAX_LOADS=16; function all_ones(NUM_LOADS).
//  Sub-module bcast_fifo2: 2-entry WIDTH storage with push/pop/head/count. The top holds done_mask, in_ready_q and the stats logic.
// TESTING
//  1 Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, no push; in_ready=1 on the first cycle after release.
//  2 Streaming: NUM_LOADS=4, out_ready=4'hF, push 0x11,0x22,0x33 back-to-back
//    -> each appears on out_data 1 cycle after push, out_valid=4'hF, in_ready stays 1.
//  3 Partial accept: item 0xAA, load 2 ready only on cycle 3, others on cycle 1
//    -> out_valid goes 4'hF -> 4'h4, then retire; 0xAA held stable throughout.
//  4 Full: out_ready=0, push 0x1,0x2 -> in_ready=0; third item held off.
//    Set out_ready=4'hF -> 0x1 then 0x2 delivered in order, then in_ready=1.
//  5 Push+retire: count=1 with head retiring and in_valid=1 (0x55) in the same cycle
//    -> count stays 1, head=0x55 next cycle, done_mask=0.
//  6 Mid-op reset: assert rst with count=2 and done_mask=4'b0011 -> all cleared, and no out_valid for the old items after release.
//  With BCAST_FANOUT_STATS_EN: scenario 3 gives stat_items=1, stat_stall=2; wrap checked by forcing 0xFFFF_FFFF.

Source files
------------

// File: rtl/bcast_pkg.sv
// Shared types and helpers for the bcast_fanout_slice registered fanout stage.
package bcast_pkg;

    localparam int unsigned MAX_LOADS = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Mask with the low n bits set, used as the "every load accepted" pattern.
    function automatic logic [MAX_LOADS-1:0] all_ones(input int unsigned n);
        logic [MAX_LOADS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LOADS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcast_fifo2.sv
// Two-entry payload store for the fanout slice: head register plus one skid entry.
module bcast_fifo2
    import bcast_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output occ_e             o_count,
    output occ_e             o_count_next
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    occ_e             r_count;
    occ_e             w_count_next;

    always_comb begin
        w_count_next = r_count;
        case (r_count)
            EMPTY:   if (i_push) w_count_next = ONE;
            ONE: begin
                if (i_push && !i_pop)      w_count_next = FULL;
                else if (i_pop && !i_push) w_count_next = EMPTY;
            end
            FULL:    if (i_pop) w_count_next = ONE;
            default: w_count_next = EMPTY;
        endcase
    end

    // Push and pop together at ONE overwrite the head in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= EMPTY;
        end else begin
            r_count <= w_count_next;
            case (r_count)
                EMPTY: if (i_push) r_head <= i_data;
                ONE: begin
                    if (i_push && i_pop) r_head <= i_data;
                    else if (i_push)     r_tail <= i_data;
                end
                FULL:  if (i_pop) r_head <= r_tail;
                default: ;
            endcase
        end
    end

    assign o_head       = r_head;
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/bcast_fanout_slice.sv
// Registered fanout of one valid/ready stream to NUM_LOADS consumers.
// Optional BCAST_FANOUT_STATS_EN adds retired-item and stall counters.
module bcast_fanout_slice
    import bcast_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_LOADS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NUM_LOADS-1:0] out_valid,
    input  logic [NUM_LOADS-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef BCAST_FANOUT_STATS_EN
    ,
    output logic [31:0]          stat_items,
    output logic [31:0]          stat_stall
`endif
);

    localparam logic [MAX_LOADS-1:0] LOAD_MASK = all_ones(NUM_LOADS);
    localparam logic [NUM_LOADS-1:0] ALL_LOADS = LOAD_MASK[NUM_LOADS-1:0];

    occ_e                 w_count;
    occ_e                 w_count_next;
    logic                 w_busy;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_LOADS-1:0] w_accept;
    logic [NUM_LOADS-1:0] r_done_mask;
    logic                 r_in_ready;

    bcast_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_data       (in_data),
        .o_head       (out_data),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    assign w_busy    = (w_count != EMPTY);
    assign out_valid = {NUM_LOADS{w_busy}} & ~r_done_mask;
    assign w_accept  = out_valid & out_ready;
    assign w_pop     = w_busy && ((r_done_mask | w_accept) == ALL_LOADS);
    assign w_push    = in_valid & r_in_ready;
    assign in_ready  = r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_mask <= '0;
            r_in_ready  <= 1'b0;
        end else begin
            r_done_mask <= w_pop ? '0 : (r_done_mask | w_accept);
            r_in_ready  <= (w_count_next != FULL);
        end
    end

`ifdef BCAST_FANOUT_STATS_EN
    logic [31:0] r_stat_items;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_items <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pop)            r_stat_items <= r_stat_items + 32'd1;
            if (w_busy && !w_pop) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_items = r_stat_items;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_bcast_fanout_slice.sv
// Scoreboard bench for bcast_fanout_slice; exercises BCAST_FANOUT_STATS_EN counters when defined.
module tb_bcast_fanout_slice;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [W-1:0]  out_data;
`ifdef BCAST_FANOUT_STATS_EN
    logic [31:0]   stat_items;
    logic [31:0]   stat_stall;
    logic [31:0]   s_items0;
    logic [31:0]   s_stall0;
`endif

    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [N-1:0]  sb_mask;

    bcast_fanout_slice #(.WIDTH(W), .NUM_LOADS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BCAST_FANOUT_STATS_EN
        ,
        .stat_items(stat_items),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one item, wait (bounded) for in_ready, record it as expected, return after the push edge.
    task automatic send(input logic [W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high data=%h", d);
        end else begin
            exp_q.push_back(d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Output monitor: every presented item must match the queue head, each load accepts once.
    always @(negedge clk) begin
        logic [N-1:0] acc;
        if (rst) begin
            exp_q.delete();
            sb_mask = '0;
        end else if (out_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", {28'd0, out_valid}, 32'd0);
            end else begin
                chk("mon_out_data", out_data, exp_q[0]);
                chk("mon_out_valid", {28'd0, out_valid}, {28'd0, ~sb_mask});
                acc = out_valid & out_ready;
                if ((sb_mask | acc) == '1) begin
                    void'(exp_q.pop_front());
                    sb_mask = '0;
                end else begin
                    sb_mask = sb_mask | acc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_mask   = '0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = '0;

        // 1: reset held with in_valid high
        repeat (3) begin
            tick();
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        end
        chk("rst_out_data", out_data, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rel_in_ready_still_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);
        chk("rel_no_push", {28'd0, out_valid}, 32'd0);

        // 2: streaming back-to-back
        out_ready = 4'hF;
        send(32'h11);
        chk("s2_data_11", out_data, 32'h11);
        chk("s2_valid_11", {28'd0, out_valid}, 32'hF);
        chk("s2_ready_11", {31'd0, in_ready}, 32'd1);
        send(32'h22);
        chk("s2_data_22", out_data, 32'h22);
        chk("s2_ready_22", {31'd0, in_ready}, 32'd1);
        send(32'h33);
        chk("s2_data_33", out_data, 32'h33);
        chk("s2_ready_33", {31'd0, in_ready}, 32'd1);
        tick();
        chk("s2_drained", {28'd0, out_valid}, 32'd0);

        // 3: partial accept, load 2 late
        out_ready = 4'b1011;
`ifdef BCAST_FANOUT_STATS_EN
        s_items0 = stat_items;
        s_stall0 = stat_stall;
`endif
        send(32'hAA);
        chk("s3_valid_c1", {28'd0, out_valid}, 32'hF);
        chk("s3_data_c1", out_data, 32'hAA);
        tick();
        chk("s3_valid_c2", {28'd0, out_valid}, 32'h4);
        chk("s3_data_c2", out_data, 32'hAA);
        tick();
        chk("s3_valid_c3", {28'd0, out_valid}, 32'h4);
        chk("s3_data_c3", out_data, 32'hAA);
        out_ready = 4'hF;
        tick();
        chk("s3_retired", {28'd0, out_valid}, 32'd0);
`ifdef BCAST_FANOUT_STATS_EN
        chk("s3_stat_items", stat_items - s_items0, 32'd1);
        chk("s3_stat_stall", stat_stall - s_stall0, 32'd2);
`endif

        // 4: fill to FULL, third item held off
        out_ready = '0;
        send(32'h1);
        chk("s4_ready_one", {31'd0, in_ready}, 32'd1);
        send(32'h2);
        chk("s4_ready_full", {31'd0, in_ready}, 32'd0);
        chk("s4_head_full", out_data, 32'h1);
        in_valid = 1'b1;
        in_data  = 32'h3;
        tick();
        chk("s4_held_ready", {31'd0, in_ready}, 32'd0);
        chk("s4_held_head", out_data, 32'h1);
        out_ready = 4'hF;
        tick();
        chk("s4_second_head", out_data, 32'h2);
        chk("s4_ready_back", {31'd0, in_ready}, 32'd1);
        send(32'h3);
        chk("s4_third_head", out_data, 32'h3);
        tick();
        chk("s4_drained", {28'd0, out_valid}, 32'd0);
        chk("s4_ready_end", {31'd0, in_ready}, 32'd1);

        // 5: push and retire in the same cycle at ONE
        out_ready = '0;
        send(32'h44);
        out_ready = 4'hF;
        send(32'h55);
        chk("s5_head", out_data, 32'h55);
        chk("s5_valid", {28'd0, out_valid}, 32'hF);
        chk("s5_ready", {31'd0, in_ready}, 32'd1);
        out_ready = '0;
        tick();
        chk("s5_hold_valid", {28'd0, out_valid}, 32'hF);
        chk("s5_hold_head", out_data, 32'h55);
        out_ready = 4'hF;
        tick();
        chk("s5_drained", {28'd0, out_valid}, 32'd0);

        // 6: reset while FULL with a partial done mask
        out_ready = '0;
        send(32'h61);
        send(32'h62);
        out_ready = 4'b0011;
        tick();
        chk("s6_partial", {28'd0, out_valid}, 32'hC);
        rst       = 1'b1;
        out_ready = '0;
        tick();
        chk("s6_rst_valid", {28'd0, out_valid}, 32'd0);
        chk("s6_rst_ready", {31'd0, in_ready}, 32'd0);
        rst       = 1'b0;
        out_ready = 4'hF;
        tick();
        chk("s6_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("s6_rel_valid0", {28'd0, out_valid}, 32'd0);
        tick();
        chk("s6_rel_valid1", {28'd0, out_valid}, 32'd0);

`ifdef BCAST_FANOUT_STATS_EN
        // Counter wrap
        force dut.r_stat_items = 32'hFFFF_FFFF;
        #1;
        release dut.r_stat_items;
        send(32'h77);
        tick();
        chk("stat_items_wrap", stat_items, 32'd0);
        out_ready = '0;
        send(32'h78);
        force dut.r_stat_stall = 32'hFFFF_FFFF;
        #1;
        release dut.r_stat_stall;
        tick();
        chk("stat_stall_wrap", stat_stall, 32'd0);
        out_ready = 4'hF;
        tick();
`endif

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
